// File: rtl/sram_arb_pkg.sv
// Shared IDs, transfer sizes and request payload type for the SRAM-like arbiter.
package sram_arb_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    function automatic sram_req_t pack_req(input logic wr, input logic [1:0] size,
                                           input logic [31:0] addr, input logic [31:0] wdata);
        sram_req_t r;
        r.wr    = wr;
        r.size  = size;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/sram_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for accepted-but-unanswered transfers.
module sram_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg];

    // Storage needs no reset: entries are only read while counted as valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && wr_ptr_reg == PTR_W'(gi))
                    mem_reg[gi] <= din;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges instruction and data SRAM-like ports onto one master port.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin on contention (default: data over inst).
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);
    logic      lock_reg;
    logic      lock_grant_reg;
    logic      grant;
    logic      grant_valid;
    logic      accept;
    logic      resp_valid;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_head;
    sram_req_t i_pkt;
    sram_req_t d_pkt;
    sram_req_t m_pkt;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_winner_reg;

    always_ff @(posedge clk) begin
        if (rst)
            last_winner_reg <= ID_INST;
        else if (accept)
            last_winner_reg <= grant;
    end
`endif

    // While locked the stalled requester keeps the port regardless of priority.
    always_comb begin
        grant       = ID_INST;
        grant_valid = 1'b0;
        if (lock_reg) begin
            grant       = lock_grant_reg;
            grant_valid = (lock_grant_reg == ID_DATA) ? d_req : i_req;
        end else if (i_req && d_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            grant = ~last_winner_reg;
`else
            grant = ID_DATA;
`endif
            grant_valid = 1'b1;
        end else if (d_req) begin
            grant       = ID_DATA;
            grant_valid = 1'b1;
        end else if (i_req) begin
            grant       = ID_INST;
            grant_valid = 1'b1;
        end
    end

    assign i_pkt = pack_req(i_wr, i_size, i_addr, i_wdata);
    assign d_pkt = pack_req(d_wr, d_size, d_addr, d_wdata);
    assign m_pkt = grant_valid ? ((grant == ID_DATA) ? d_pkt : i_pkt) : '0;

    // Full blocks m_req even on a same-cycle pop, keeping m_data_ok off the m_req path.
    assign m_req   = grant_valid & ~fifo_full;
    assign m_wr    = m_pkt.wr;
    assign m_size  = m_pkt.size;
    assign m_addr  = m_pkt.addr;
    assign m_wdata = m_pkt.wdata;

    assign accept    = m_req & m_addr_ok;
    assign i_addr_ok = accept & (grant == ID_INST);
    assign d_addr_ok = accept & (grant == ID_DATA);

    assign resp_valid = m_data_ok & ~fifo_empty;
    assign i_data_ok  = resp_valid & (fifo_head == ID_INST);
    assign d_data_ok  = resp_valid & (fifo_head == ID_DATA);
    assign i_rdata    = m_rdata;
    assign d_rdata    = m_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_reg       <= 1'b0;
            lock_grant_reg <= ID_INST;
        end else if (!lock_reg) begin
            if (m_req && !m_addr_ok) begin
                lock_reg       <= 1'b1;
                lock_grant_reg <= grant;
            end
        end else if (m_addr_ok) begin
            lock_reg <= 1'b0;
        end
    end

    sram_id_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .pop  (m_data_ok),
        .din  (grant),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (fifo_head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: reset, contention, lock, full, routing/wrap, contention pattern.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size, m_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    sram_like_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && m_req && m_addr_ok)
            $display("[%0t] accept %s addr=%h wr=%0d", $time, d_addr_ok ? "D" : "I", m_addr, m_wr);
        if (!rst && (i_data_ok || d_data_ok))
            $display("[%0t] response %s rdata=%h", $time, d_data_ok ? "D" : "I", m_rdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic pat [10];
    logic exp_g [4];

    initial begin
        pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst = 1'b1;
        i_req = 1'b1; i_wr = 1'b0; i_size = 2'd2; i_addr = 32'hBFC00000; i_wdata = '0;
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h80001000; d_wdata = '0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: with requests gone and stray handshakes, nothing fires (empty FIFO drops data_ok)
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        settle();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        cyc();
        m_data_ok = 1'b0;

        // Contention: data wins, inst next cycle, responses in acceptance order
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1; d_wdata = 32'hDEADBEEF; m_addr_ok = 1'b1;
        settle();
        chk("cont_m_addr0", m_addr, 32'h80001000);
        chk("cont_m_wdata0", m_wdata, 32'hDEADBEEF);
        chk("cont_m_wr0", 32'(m_wr), 32'd1);
        chk("cont_addr_ok0", {30'd0, i_addr_ok, d_addr_ok}, 32'd1);
        cyc();
        d_req = 1'b0; d_wr = 1'b0;
        settle();
        chk("cont_m_addr1", m_addr, 32'hBFC00000);
        chk("cont_addr_ok1", {30'd0, i_addr_ok, d_addr_ok}, 32'd2);
        cyc();
        i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h11111111;
        settle();
        chk("cont_data_ok0", {30'd0, i_data_ok, d_data_ok}, 32'd1);
        chk("cont_d_rdata", d_rdata, 32'h11111111);
        cyc();
        m_rdata = 32'h22222222;
        settle();
        chk("cont_data_ok1", {30'd0, i_data_ok, d_data_ok}, 32'd2);
        chk("cont_i_rdata", i_rdata, 32'h22222222);
        cyc();
        m_data_ok = 1'b0;

        // Lock: inst stalls 3 cycles, data arrives meanwhile but must wait
        i_req = 1'b1; m_addr_ok = 1'b0; d_addr = 32'h80002000;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) d_req = 1'b1;
            settle();
            chk($sformatf("lock_m_addr%0d", c), m_addr, 32'hBFC00000);
            chk($sformatf("lock_m_req%0d", c), 32'(m_req), 32'd1);
            chk($sformatf("lock_addr_ok%0d", c), {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
            cyc();
        end
        m_addr_ok = 1'b1;
        settle();
        chk("lock_m_addr3", m_addr, 32'hBFC00000);
        chk("lock_addr_ok3", {30'd0, i_addr_ok, d_addr_ok}, 32'd2);
        cyc();
        i_req = 1'b0;
        settle();
        chk("lock_m_addr4", m_addr, 32'h80002000);
        chk("lock_addr_ok4", {30'd0, i_addr_ok, d_addr_ok}, 32'd1);
        cyc();
        d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        settle();
        chk("lock_resp0", {30'd0, i_data_ok, d_data_ok}, 32'd2);
        cyc();
        settle();
        chk("lock_resp1", {30'd0, i_data_ok, d_data_ok}, 32'd1);
        cyc();
        m_data_ok = 1'b0;

        // Full: four inst reads outstanding blocks the fifth
        i_req = 1'b1; m_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_addr = 32'h100 + 32'(4 * k);
            settle();
            chk($sformatf("full_fill%0d", k), {30'd0, m_req, i_addr_ok}, 32'd3);
            cyc();
        end
        i_addr = 32'h110;
        settle();
        chk("full_blocked", {30'd0, m_req, i_addr_ok}, 32'd0);
        cyc();
        m_data_ok = 1'b1; m_rdata = 32'hAAAA0000;
        settle();
        chk("full_pop_data_ok", 32'(i_data_ok), 32'd1);
        chk("full_pop_m_req", 32'(m_req), 32'd0);
        cyc();
        m_data_ok = 1'b0;
        settle();
        chk("full_reopen", {30'd0, m_req, i_addr_ok}, 32'd3);
        cyc();
        i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("full_drain%0d", k), {30'd0, i_data_ok, d_data_ok}, 32'd2);
            cyc();
        end
        settle();
        chk("full_empty_drop", {30'd0, i_data_ok, d_data_ok}, 32'd0);
        cyc();
        m_data_ok = 1'b0;

        // Routing/wrap: I,D,D,I,... with each response one cycle after its accept
        for (int k = 0; k <= 10; k++) begin
            i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0;
            if (k < 10) begin
                m_addr_ok = 1'b1;
                if (pat[k]) begin d_req = 1'b1; d_addr = 32'h1000 + 32'(k); end
                else        begin i_req = 1'b1; i_addr = 32'h1000 + 32'(k); end
            end
            m_data_ok = (k > 0);
            m_rdata = 32'hC0DE0000 + 32'(k - 1);
            settle();
            if (k < 10) begin
                chk($sformatf("route_m_addr%0d", k), m_addr, 32'h1000 + 32'(k));
                chk($sformatf("route_addr_ok%0d", k), {30'd0, i_addr_ok, d_addr_ok},
                    pat[k] ? 32'd1 : 32'd2);
            end
            if (k > 0) begin
                chk($sformatf("route_data_ok%0d", k - 1), {30'd0, i_data_ok, d_data_ok},
                    pat[k - 1] ? 32'd1 : 32'd2);
                chk($sformatf("route_rdata%0d", k - 1), pat[k - 1] ? d_rdata : i_rdata,
                    32'hC0DE0000 + 32'(k - 1));
            end
            cyc();
        end
        m_data_ok = 1'b0;

        // Continuous contention after an inst-only accept
        i_req = 1'b1; d_req = 1'b0; m_addr_ok = 1'b1; i_addr = 32'h2000; d_addr = 32'h3000;
        settle();
        chk("arb_pre", {30'd0, i_addr_ok, d_addr_ok}, 32'd2);
        cyc();
        d_req = 1'b1; m_data_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("arb_grant%0d", k), {30'd0, i_addr_ok, d_addr_ok},
                exp_g[k] ? 32'd1 : 32'd2);
            if (k == 0)
                chk("arb_resp0", {30'd0, i_data_ok, d_data_ok}, 32'd2);
            else
                chk($sformatf("arb_resp%0d", k), {30'd0, i_data_ok, d_data_ok},
                    exp_g[k - 1] ? 32'd1 : 32'd2);
            cyc();
        end
        i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0;
        settle();
        chk("arb_resp_last", {30'd0, i_data_ok, d_data_ok}, exp_g[3] ? 32'd1 : 32'd2);
        cyc();
        m_data_ok = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like master port between two SRAM-like requesters: instruction (port i, ID 0) and data (port d, ID 1).
- Sits between the pipeline fetch/memory stages and the AXI bridge, so the bridge sees a single requester.
- Keeps an in-order FIFO of requester IDs for accepted-but-unanswered transactions, so each m_data_ok/m_rdata is routed back to its owner.
- Downstream responses are required to return in acceptance order.

Parameters:
- MAX_OUTSTANDING, 4: depth of the ID FIFO, i.e. the maximum number of accepted-but-unanswered transactions; power of two, ≥2.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- i_req/i_wr  in  1/1  inst request, write flag
- i_size  in  2  0=byte, 1=half, 2=word
- i_addr/i_wdata  in  32/32  inst address, write data
- i_rdata  out  32  inst read data
- i_addr_ok/i_data_ok  out  1/1  inst handshakes
- d_req/d_wr  in  1/1  data request, write flag
- d_size  in  2  data size
- d_addr/d_wdata  in  32/32  data address, write data
- d_rdata  out  32  data read data
- d_addr_ok/d_data_ok  out  1/1  data handshakes
- m_req/m_wr  out  1/1  merged request, write flag
- m_size  out  2  merged size
- m_addr/m_wdata  out  32/32  merged address, write data
- m_rdata  in  32  downstream read data
- m_addr_ok/m_data_ok  in  1/1  downstream handshakes

Behaviour:
- Reset (rst=1 at a clock edge): FIFO empty, count=0, lock=0, last_winner=ID 0. All outputs then read 0.
- Grant selection (combinational) is used when lock=0:
  - fixed priority, data over inst;
  - the only requester present wins;
  - no winner when neither requests.
- Lock: if m_req=1 and m_addr_ok=0, the next cycle sets lock=1 and holds the same grant until m_addr_ok. This satisfies the SRAM-like rule that req and payload stay stable until addr_ok. Lock clears on the addr_ok cycle.
- Pass-through:
  - m_req = granted_req & (count<MAX_OUTSTANDING);
  - m_wr/m_size/m_addr/m_wdata mux from the granted requester; 0 when there is no grant.
- Full: when count==MAX_OUTSTANDING, m_req=0 even if a pop happens in the same cycle. This gives no combinational path from m_data_ok to m_req.
- Address handshake: i_addr_ok = m_addr_ok & grant==0; d_addr_ok = m_addr_ok & grant==1. Both are combinational, zero latency.
- Push: on m_req & m_addr_ok, push the grant ID.
- Pop: on m_data_ok & count>0, pop the head.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers are log2(MAX_OUTSTANDING) bits and wrap naturally; count is log2(MAX_OUTSTANDING)+1 bits.
- Response routing (combinational from FIFO head):
  - i_data_ok = m_data_ok & count>0 & head==0;
  - d_data_ok = m_data_ok & count>0 & head==1;
  - i_rdata = d_rdata = m_rdata, unqualified; consumers qualify with data_ok.
- m_data_ok while count==0 is a protocol violation: dropped, no state change.
- Same-cycle accept and response for a request issued on an empty FIFO is not allowed; downstream data_ok latency is ≥1 cycle after addr_ok.
- rst asserted mid-operation: all tracking is discarded and a fresh reset is required downstream as well. The system resets all blocks together.

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - on contention with lock=0, the requester that did not win the last accepted transfer is granted;
  - last_winner updates on every m_req & m_addr_ok;
  - an uncontended request is granted immediately.
- Undefined: fixed priority (data over inst); last_winner register is absent.

Decomposition:
- Package sram_arb_pkg:
  - ID_INST=1'b0, ID_DATA=1'b1;
  - SIZE_BYTE/HALF/WORD=2'd0/1/2;
  - typedef sram_req_t {wr, size, addr, wdata}.
- Sub-module sram_id_fifo (DEPTH, 1-bit data, push/pop/full/empty/head), instantiated once.
- Arbitration and lock logic stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with i_req=d_req=1 → afterwards m_req=0, all addr_ok/data_ok=0, count=0.
- Contention, fixed priority:
  - i_req=d_req=1 with i_addr=0xBFC00000, d_addr=0x80001000, m_addr_ok=1 every cycle, data_ok 2 cycles later;
  - expect: d accepted first (m_addr=0x80001000, d_addr_ok=1), inst accepted next cycle, d_data_ok precedes i_data_ok.
- Lock:
  - i_req alone, m_addr_ok held 0 for 3 cycles, d_req rises in cycle 1;
  - expect: m_addr stays 0xBFC00000 for all 3 cycles, i_addr_ok on the 4th cycle, then d granted.
- Full:
  - 4 inst reads accepted with no data_ok → 5th request sees m_req=0;
  - one m_data_ok → i_data_ok=1, and the following cycle m_req=1 again.
- Routing/wrap:
  - 10 alternating reads with pattern I,D,D,I,... and data_ok returning 1 cycle after each addr_ok;
  - expect: each data_ok goes to the correct port with the matching m_rdata, and the pointers wrap twice.
- SRAM_ARB_ROUND_ROBIN_EN: i_req=d_req=1 continuously with m_addr_ok=1 → grants alternate D,I,D,I.
